// File: rtl/alu_arbiter_pkg.sv
// Shared encodings for the adder/comparator arbiter.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_0 = 2'd1,
    GRANT_1 = 2'd2
  } arb_state_e;

  localparam logic CLIENT_0 = 1'b0;
  localparam logic CLIENT_1 = 1'b1;

endpackage

// File: rtl/Adder.sv
// Shared N-bit adder; carry-out is not produced, so the sum wraps modulo 2^N.
module Adder #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] i_augend,
  input  logic [N-1:0] i_addend,
  output logic [N-1:0] o_sum
);

  assign o_sum = i_augend + i_addend;

endmodule

// File: rtl/Comparator.sv
// Shared N-bit equality comparator.
module Comparator #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] i_left,
  input  logic [N-1:0] i_right,
  output logic         o_equal
);

  assign o_equal = (i_left == i_right);

endmodule

// File: rtl/arbiter_rr2.sv
// Two-client round-robin lock: state register, last-served priority and grant decode.
module arbiter_rr2
  import alu_arbiter_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_request_0,
  input  logic i_request_1,
  output logic o_grant_0,
  output logic o_grant_1,
  output logic o_busy
);

  arb_state_e state_q, state_d;
  logic       last_served_q, last_served_d;

  // Next-state: a held request keeps the lock; a release hands over directly to a waiting client.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    unique case (state_q)
      IDLE: begin
        if (i_request_0 && i_request_1)
          state_d = (last_served_q == CLIENT_1) ? GRANT_0 : GRANT_1;
        else if (i_request_0)
          state_d = GRANT_0;
        else if (i_request_1)
          state_d = GRANT_1;
        else
          state_d = IDLE;
      end
      GRANT_0: begin
        if (i_request_0)      state_d = GRANT_0;
        else if (i_request_1) state_d = GRANT_1;
        else                  state_d = IDLE;
      end
      GRANT_1: begin
        if (i_request_1)      state_d = GRANT_1;
        else if (i_request_0) state_d = GRANT_0;
        else                  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == GRANT_0) last_served_d = CLIENT_0;
    if (state_d == GRANT_1) last_served_d = CLIENT_1;
  end

  // State and priority registers; reset favours client 0 on the first tie.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= IDLE;
      last_served_q <= CLIENT_1;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
    end
  end

  assign o_grant_0 = (state_q == GRANT_0);
  assign o_grant_1 = (state_q == GRANT_1);
  assign o_busy    = o_grant_0 | o_grant_1;

endmodule

// File: rtl/alu_arbiter.sv
// Lends one shared adder and comparator to whichever of two clients holds the grant.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_request_0,
  input  logic         i_request_1,
  output logic         o_grant_0,
  output logic         o_grant_1,
  output logic         o_busy,
  input  logic [N-1:0] i_augend_0,
  input  logic [N-1:0] i_addend_0,
  input  logic [N-1:0] i_left_0,
  input  logic [N-1:0] i_right_0,
  output logic [N-1:0] o_sum_0,
  output logic         o_equal_0,
  input  logic [N-1:0] i_augend_1,
  input  logic [N-1:0] i_addend_1,
  input  logic [N-1:0] i_left_1,
  input  logic [N-1:0] i_right_1,
  output logic [N-1:0] o_sum_1,
  output logic         o_equal_1
);

  logic         grant_0, grant_1;
  logic [N-1:0] add_a, add_b, cmp_a, cmp_b;
  logic [N-1:0] sum;
  logic         equal;

  arbiter_rr2 u_arbiter (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_request_0 (i_request_0),
    .i_request_1 (i_request_1),
    .o_grant_0   (grant_0),
    .o_grant_1   (grant_1),
    .o_busy      (o_busy)
  );

  assign o_grant_0 = grant_0;
  assign o_grant_1 = grant_1;

  // Operand mux: the granted client drives the resources, idle forces zeros.
  always_comb begin
    add_a = '0;
    add_b = '0;
    cmp_a = '0;
    cmp_b = '0;
    if (grant_0) begin
      add_a = i_augend_0;
      add_b = i_addend_0;
      cmp_a = i_left_0;
      cmp_b = i_right_0;
    end else if (grant_1) begin
      add_a = i_augend_1;
      add_b = i_addend_1;
      cmp_a = i_left_1;
      cmp_b = i_right_1;
    end
  end

  Adder #(.N(N)) u_adder (
    .i_augend (add_a),
    .i_addend (add_b),
    .o_sum    (sum)
  );

  Comparator #(.N(N)) u_comparator (
    .i_left  (cmp_a),
    .i_right (cmp_b),
    .o_equal (equal)
  );

  // Result gating: idle's 0==0 must not leak out as equal=1 to either client.
  always_comb begin
    o_sum_0   = grant_0 ? sum : '0;
    o_equal_0 = grant_0 & equal;
    o_sum_1   = grant_1 ? sum : '0;
    o_equal_1 = grant_1 & equal;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (N=4): handshake, fairness, lock, async reset, datapath gating.
module tb_alu_arbiter;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic         g0, g1, busy;
  logic [N-1:0] aug0, add0, left0, right0, sum0;
  logic [N-1:0] aug1, add1, left1, right1, sum1;
  logic         eq0, eq1;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.N(N)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_request_0 (req0),
    .i_request_1 (req1),
    .o_grant_0   (g0),
    .o_grant_1   (g1),
    .o_busy      (busy),
    .i_augend_0  (aug0),
    .i_addend_0  (add0),
    .i_left_0    (left0),
    .i_right_0   (right0),
    .o_sum_0     (sum0),
    .o_equal_0   (eq0),
    .i_augend_1  (aug1),
    .i_addend_1  (add1),
    .i_left_1    (left1),
    .i_right_1   (right1),
    .o_sum_1     (sum1),
    .o_equal_1   (eq1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " g0"}, g0, 0);
    check({tag, " g1"}, g1, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " sum0"}, sum0, 0);
    check({tag, " sum1"}, sum1, 0);
    check({tag, " eq0"}, eq0, 0);
    check({tag, " eq1"}, eq1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0;
    aug0 = 0; add0 = 0; left0 = 0; right0 = 0;
    aug1 = 0; add1 = 0; left1 = 0; right1 = 0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: reset state, single request, latency and datapath
    check_idle("reset");
    req0 = 1; aug0 = 3; add0 = 4; left0 = 5; right0 = 5;
    aug1 = 9; add1 = 9; left1 = 2; right1 = 2;
    #1;
    check("latency g0", g0, 0);
    tick();
    check("t1 g0", g0, 1);
    check("t1 busy", busy, 1);
    check("t1 sum0", sum0, 7);
    check("t1 eq0", eq0, 1);
    check("t1 sum1", sum1, 0);
    check("t1 eq1", eq1, 0);

    // 6: single client releases with nobody waiting
    req0 = 0;
    tick();
    check_idle("release");

    // 2: simultaneous requests after reset, then direct handover
    rst = 1; #2; rst = 0;
    req0 = 1; req1 = 1;
    tick();
    check("t2 g0 first", g0, 1);
    check("t2 g1 first", g1, 0);
    req0 = 0;
    tick();
    check("t2 handover g1", g1, 1);
    check("t2 handover g0", g0, 0);
    check("t2 handover busy", busy, 1);
    req1 = 0;
    tick();
    check("t2 end busy", busy, 0);

    // 3: fairness 0,1,0,1 with full release between rounds, plus wrap on client 1
    aug1 = 12; add1 = 7;
    for (int i = 0; i < 4; i++) begin
      req0 = 1; req1 = 1;
      tick();
      check($sformatf("rr%0d g0", i), g0, ((i % 2) == 0) ? 1 : 0);
      check($sformatf("rr%0d g1", i), g1, ((i % 2) == 1) ? 1 : 0);
      if (i == 1) check("wrap sum1", sum1, 3);
      req0 = 0; req1 = 0;
      tick();
      check($sformatf("rr%0d idle", i), busy, 0);
    end

    // 4: lock held by client 0 against a waiting client 1 with moving operands
    req0 = 1; req1 = 1;
    tick();
    check("lock enter g0", g0, 1);
    for (int i = 0; i < 10; i++) begin
      aug1 = 4'(i); add1 = 4'(15 - i); left1 = 4'(i); right1 = 4'(i + 1);
      tick();
      check($sformatf("lock%0d g1", i), g1, 0);
      check($sformatf("lock%0d sum0", i), sum0, 7);
      check($sformatf("lock%0d eq0", i), eq0, 1);
    end
    check("lock sum1", sum1, 0);

    // 5: asynchronous reset mid-cycle during GRANT_1
    req0 = 0;
    tick();
    check("t5 g1", g1, 1);
    check("t5 g0", g0, 0);
    aug1 = 2; add1 = 3; left1 = 6; right1 = 6;
    #1;
    check("t5 sum1", sum1, 5);
    check("t5 eq1", eq1, 1);
    #2;
    rst = 1;
    #1;
    check("async g1", g1, 0);
    check("async busy", busy, 0);
    check("async sum0", sum0, 0);
    check("async sum1", sum1, 0);
    check("async eq1", eq1, 0);
    #2;
    rst = 0;
    req0 = 1; req1 = 1;
    tick();
    check("post-reset g0", g0, 1);
    check("post-reset g1", g1, 0);

    // 6: everyone releases
    req0 = 0; req1 = 0;
    tick();
    check_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
